// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// FSM state enum, scancode constants, frame size, parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = FRAME_BITS - 3;

    // Odd parity: data bits plus parity bit hold an odd number of ones
    function automatic logic parity_ok(input logic [7:0] b,
                                       input logic       p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchroniser for raw PS/2 clock/data plus ps2_clk falling-edge detect.
// Ports: clk, reset (async low), ps2_clk, ps2_data in; fall, data_s out.
module ps2_sync_edge
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] data_sr;
    logic                   clk_prev;

    // Chains reset to 1 so a released reset on an idle bus is no edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sr   <= '1;
            data_sr  <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
            data_sr  <= {data_sr[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sr[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sr[SYNC_STAGES-1];
    assign data_s = data_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard front end: frames, E0/F0 prefixes, arrow flags.
// Ports: clk, reset (async low), ps2_clk, ps2_data in; code, code_valid,
// code_ext, code_break, frame_err, key_up/down/left/right out.
// Option: PS2_TYPEMATIC_FILTER_EN suppresses repeated makes.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       code_ext,
    output logic       code_break,
    output logic       frame_err,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic       fall;
    logic       data_s;

    ps2_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       par;
    logic [TW-1:0] tcnt;
    logic       ext;
    logic       brk;
    logic       byte_ok;
    logic       timeout;
    logic       suppress;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_s   (data_s)
    );

    // Stop bit is data_s at the STOP-state fall
    assign byte_ok = parity_ok(shift, par) & data_s;

    // A fall in the same cycle as expiry keeps the frame alive
    assign timeout = (state != IDLE) && !fall
                   && (tcnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       last_vld;
    logic [8:0] last_key;

    assign suppress = !brk && last_vld
                    && (last_key == {ext, shift});
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            tcnt       <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            code       <= '0;
            code_valid <= 1'b0;
            code_ext   <= 1'b0;
            code_break <= 1'b0;
            frame_err  <= 1'b0;
            key_up     <= 1'b0;
            key_down   <= 1'b0;
            key_left   <= 1'b0;
            key_right  <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_vld   <= 1'b0;
            last_key   <= '0;
`endif
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (fall || state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt != '1) begin
                tcnt <= tcnt + 1'b1;
            end

            if (timeout) begin
                // Prefix flags survive: the keyboard may resend the byte
                state     <= IDLE;
                bit_cnt   <= '0;
                shift     <= '0;
                frame_err <= 1'b1;
            end else if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= data_s;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!byte_ok) begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end else if (shift == SC_EXT) begin
                            ext <= 1'b1;
                        end else if (shift == SC_BREAK) begin
                            brk <= 1'b1;
                        end else begin
                            ext <= 1'b0;
                            brk <= 1'b0;
                            if (!suppress) begin
                                code       <= shift;
                                code_ext   <= ext;
                                code_break <= brk;
                                code_valid <= 1'b1;
                                // Keypad keys share codes; only E0 ones count
                                if (ext) begin
                                    unique case (shift)
                                        SC_UP:    key_up    <= ~brk;
                                        SC_DOWN:  key_down  <= ~brk;
                                        SC_LEFT:  key_left  <= ~brk;
                                        SC_RIGHT: key_right <= ~brk;
                                        default:  ;
                                    endcase
                                end
`ifdef PS2_TYPEMATIC_FILTER_EN
                                if (brk) begin
                                    last_vld <= 1'b0;
                                end else begin
                                    last_vld <= 1'b1;
                                    last_key <= {ext, shift};
                                end
`endif
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx with a code_valid scoreboard.
// Honours PS2_TYPEMATIC_FILTER_EN for the repeat-make expectations.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    // Device clock scaled: 80-cycle period vs 200-cycle timeout
    localparam int HALF = 40;
    localparam int TOUT = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ext;
    logic       code_break;
    logic       frame_err;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;

    ps2_keyboard_rx #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid),
        .code_ext   (code_ext),
        .code_break (code_break),
        .frame_err  (frame_err),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_exp = 0;
    logic [9:0] exp_q[$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every code_valid pops one expected {ext,brk,code}
    always @(negedge clk) begin
        if (reset && code_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_code observed=%0h expected=none",
                       {code_ext, code_break, code});
            end
            if (exp_q.size() != 0) begin
                logic [9:0] e;
                e = exp_q.pop_front();
                checks++;
                assert ({code_ext, code_break, code} === e) else begin
                    errors++;
                    $error("FAIL code_event observed=%0h expected=%0h",
                           {code_ext, code_break, code}, e);
                end
            end
        end
        if (reset && frame_err) err_seen++;
    end

    function automatic logic [10:0] mk(input logic [7:0] b,
                                       input logic pflip,
                                       input logic stop);
        return {stop, (~^b) ^ pflip, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk(b, 1'b0, 1'b1), 11);
    endtask

    task automatic push(input logic e, input logic b, input logic [7:0] c);
        exp_q.push_back({e, b, c});
    endtask

    initial begin
        repeat (4) @(negedge clk);
        #1;
        chk("reset_outputs",
            {code, code_valid, code_ext, code_break, frame_err,
             key_up, key_down, key_left, key_right}, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Plain make
        push(1'b0, 1'b0, 8'h1C);
        send_byte(8'h1C);
        chk("code_hold_1c", code, 8'h1C);
        chk("frame_err_none", err_seen, err_exp);

        // Up arrow make then release
        push(1'b1, 1'b0, SC_UP);
        send_byte(SC_EXT);
        chk("up_before", key_up, 0);
        send_byte(SC_UP);
        chk("up_held", key_up, 1);
        push(1'b1, 1'b1, SC_UP);
        send_byte(SC_EXT);
        send_byte(SC_BREAK);
        chk("up_held_prefix", key_up, 1);
        send_byte(SC_UP);
        chk("up_released", key_up, 0);

        // Keypad 8 shares code 75 but must not touch the flag
        push(1'b0, 1'b0, SC_UP);
        send_byte(SC_UP);
        chk("keypad_no_flag", key_up, 0);

        // Two arrows held together
        push(1'b1, 1'b0, SC_UP);
        send_byte(SC_EXT);
        send_byte(SC_UP);
        push(1'b1, 1'b0, SC_DOWN);
        send_byte(SC_EXT);
        send_byte(SC_DOWN);
        chk("two_held", {key_up, key_down}, 2'b11);

        // Parity error, then extended break of down
        send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
        err_exp++;
        chk("parity_err", err_seen, err_exp);
        push(1'b1, 1'b1, SC_DOWN);
        send_byte(SC_EXT);
        send_byte(SC_BREAK);
        send_byte(SC_DOWN);
        chk("down_released", {key_up, key_down}, 2'b10);

        // A bad frame clears a pending E0 prefix
        send_byte(SC_EXT);
        send_bits(mk(8'h33, 1'b0, 1'b0), 11);
        err_exp++;
        chk("stop_err", err_seen, err_exp);
        push(1'b0, 1'b0, SC_DOWN);
        send_byte(SC_DOWN);
        chk("prefix_cleared", key_down, 0);

        // Release up
        push(1'b1, 1'b1, SC_UP);
        send_byte(SC_EXT);
        send_byte(SC_BREAK);
        send_byte(SC_UP);
        chk("up_released2", key_up, 0);

        // Timeout mid-frame, then a clean frame
        send_bits(mk(8'h29, 1'b0, 1'b1), 5);
        repeat (TOUT + 20) @(negedge clk);
        err_exp++;
        chk("timeout_err", err_seen, err_exp);
        push(1'b0, 1'b0, 8'h29);
        send_byte(8'h29);
        chk("after_timeout", code, 8'h29);

        // Timeout keeps a pending E0 prefix
        push(1'b1, 1'b0, SC_UP);
        send_byte(SC_EXT);
        send_bits(mk(SC_UP, 1'b0, 1'b1), 5);
        repeat (TOUT + 20) @(negedge clk);
        err_exp++;
        send_byte(SC_UP);
        chk("prefix_kept", key_up, 1);
        chk("timeout_err2", err_seen, err_exp);
        push(1'b1, 1'b1, SC_UP);
        send_byte(SC_EXT);
        send_byte(SC_BREAK);
        send_byte(SC_UP);

        // Fall with data high in IDLE is a bad start bit
        send_bits(11'h7FF, 1);
        err_exp++;
        repeat (4) @(negedge clk);
        chk("bad_start", err_seen, err_exp);

        // Reset in the middle of a frame
        push(1'b1, 1'b0, SC_RIGHT);
        send_byte(SC_EXT);
        send_byte(SC_RIGHT);
        chk("right_held", key_right, 1);
        send_bits(mk(SC_EXT, 1'b0, 1'b1), 6);
        reset = 1'b0;
        #1;
        chk("reset_midframe",
            {code, code_valid, code_ext, code_break, frame_err,
             key_up, key_down, key_left, key_right}, 0);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        push(1'b0, 1'b0, SC_RIGHT);
        send_byte(SC_RIGHT);
        chk("right_after_reset", key_right, 0);
        chk("no_err_on_reset", err_seen, err_exp);

        // Typematic repeats of left arrow
        push(1'b1, 1'b0, SC_LEFT);
`ifndef PS2_TYPEMATIC_FILTER_EN
        push(1'b1, 1'b0, SC_LEFT);
        push(1'b1, 1'b0, SC_LEFT);
`endif
        for (int i = 0; i < 3; i++) begin
            send_byte(SC_EXT);
            send_byte(SC_LEFT);
        end
        chk("left_held", key_left, 1);
        chk("repeat_drained", exp_q.size(), 0);
        push(1'b1, 1'b1, SC_LEFT);
        send_byte(SC_EXT);
        send_byte(SC_BREAK);
        send_byte(SC_LEFT);
        chk("left_released", key_left, 0);
        push(1'b1, 1'b0, SC_LEFT);
        send_byte(SC_EXT);
        send_byte(SC_LEFT);
        chk("left_again", key_left, 1);

        repeat (50) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("frame_err_total", err_seen, err_exp);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
